// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Holds the FSM state encoding, program size limit and checksum width.
package inst_mem_loader_pkg;

    localparam int MAX_WORDS = 64;
    localparam int CSUM_W    = 8;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input, instruction memory write port and status of the loader.
// master drives the stream and start; slave is the loader itself.
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
);

    logic              start;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed program into instruction memory
// one byte at a time, holding the CPU until the load completes.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int MAX_WORDS = inst_mem_loader_pkg::MAX_WORDS,
    parameter int ADDR_W    = 8
) (
    input logic              clk,
    input logic              rst,
    inst_mem_loader_if.slave bus
);

    // One extra bit so a full-size program ends at 4*MAX_WORDS, not 0.
    localparam int CNT_W = $clog2(4 * MAX_WORDS + 1);
    localparam logic [BYTE_W-1:0] MAX_N = BYTE_W'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;

    logic busy;
    logic acc;

    assign busy = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign acc  = bus.in_valid && busy;

    assign bus.in_ready  = busy;
    assign bus.cpu_hold  = busy || we_q;
    assign bus.load_done = (state_q == DONE);
    assign bus.load_err  = err_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            total_q <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        csum_d  = csum_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = LEN;
                    cnt_d   = '0;
                    csum_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LEN: begin
                if (acc) begin
                    if (bus.in_data == '0 || bus.in_data > MAX_N) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        total_d = CNT_W'({bus.in_data, 2'b00});
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'(cnt_q);
                    wdata_d = bus.in_data;
                    csum_d  = csum_q ^ bus.in_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == total_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (acc) begin
                    state_d = DONE;
                    err_d   = (bus.in_data != csum_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MAX_WORDS, default 64, largest program length in 32-bit words (256 bytes).
REQ-003 Parameter ADDR_W, default 8, byte-address width of the instruction memory write port.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 in_valid  input  1  in_data holds a valid byte.
REQ-008 in_data  input  8  incoming byte stream.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  byte write strobe to the instruction memory.
REQ-011 mem_addr  output  ADDR_W  byte address of the write.
REQ-012 mem_wdata  output  8  byte to write.
REQ-013 cpu_hold  output  1  holds the CPU while a load is in progress.
REQ-014 load_done  output  1  the last load finished; held until the next accepted start.
REQ-015 load_err  output  1  the last load failed; valid while load_done=1.

Function
REQ-016 States SHALL be IDLE, LEN, DATA, CSUM, DONE.
REQ-017 A byte transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in IDLE and DONE.
REQ-019 start in IDLE or DONE SHALL go to LEN and clear load_done, load_err, the byte counter and the checksum.
REQ-020 start in LEN, DATA or CSUM SHALL be ignored.
REQ-021 LEN: the accepted byte is N, the word count.
  - N=0 or N>MAX_WORDS: go to DONE with load_err=1.
  - Otherwise: store 4*N as the byte total and go to DATA.
REQ-022 DATA: the k-th accepted data byte (k from 0) SHALL be written to address k.
  - Result is little-endian: word w occupies addresses 4w+3..4w, LSB at 4w.
REQ-023 The write SHALL be registered: mem_we=1 for exactly one cycle, the cycle after acceptance, with mem_addr=k and mem_wdata=byte.
REQ-024 The checksum SHALL be the XOR of all DATA bytes, 8 bits, initial value 0x00.
REQ-025 After byte 4N-1 is accepted, the state SHALL move to CSUM.
  - The 9-bit counter SHALL NOT wrap: N=64 ends at count 256.
REQ-026 CSUM: the accepted byte SHALL be compared with the checksum; go to DONE with load_err=1 on mismatch, 0 on match.
REQ-027 load_done SHALL rise in the cycle the FSM enters DONE.
REQ-028 cpu_hold SHALL be 1 in LEN, DATA and CSUM.
  - It SHALL also be 1 in the cycle carrying the final mem_we pulse, and 0 otherwise.
REQ-029 in_valid with in_ready=0 SHALL cause no state change; the byte is not consumed.
REQ-030 in_valid gaps mid-stream SHALL stall without timeout.

Reset
REQ-031 rst SHALL asynchronously force the following, including mid-load:
  - state IDLE; counter 0; checksum 0x00;
  - mem_we, cpu_hold, in_ready, load_done and load_err all 0;
  - mem_addr and mem_wdata 0.
REQ-032 Bytes already written before a mid-load reset SHALL NOT be rolled back.
  - A new start SHALL be required to reload.

Structure
REQ-033 A shared package SHALL hold the state enumeration, MAX_WORDS and the checksum width.
REQ-034 No sub-module: one FSM with counter, checksum register and write register.

Verification
REQ-035 start; bytes 0x01, 0x93,0x02,0x10,0x00, 0x81 -> 4 writes at addr 0..3 = 93,02,10,00; load_done=1, load_err=0.
REQ-036 N=2, 8 bytes, wrong checksum 0x00 (correct 0x5A) -> 8 writes; load_done=1, load_err=1.
REQ-037 N=0 and separately N=65 -> no mem_we; load_done=1, load_err=1 one cycle after the length byte.
REQ-038 N=64, 256 bytes with random in_valid gaps -> last write at addr 0xFF, no address wrap; correct checksum gives load_err=0.
REQ-039 rst asserted after 5 data bytes -> all outputs 0 immediately.
  - Then start with N=1 -> write begins at addr 0.
REQ-040 start pulsed during DATA and in_valid asserted in DONE -> both ignored, counters unchanged.
